// File: rtl/jtag_tdr_bank.sv
// -----------------------------------------------------------------------------
// jtag_tdr_bank
//
// Bank of NUM_TDR JTAG test data registers of DR_LEN bits each, sharing one
// TAP data-register path, plus a 1-bit bypass register. A scan session begins
// at Capture_DR, which latches the target (TDR index or bypass). The target
// then stays fixed until the next Capture_DR. An update is committed only when
// the session shifted exactly DR_LEN bits. Otherwise length_err is raised and
// the update stage is left untouched.
//
// Ports
//   TCK            test clock; all state changes on its rising edge
//   RST            synchronous, active-high reset
//   tdr_en         1 = TDR path selected by the instruction decoder, 0 = bypass
//   tdr_sel        TDR index, sampled only on Capture_DR
//   TDI            serial data in
//   Capture_DR     capture strobe from the TAP (highest priority)
//   Shift_DR       shift enable from the TAP
//   Update_DR      update strobe from the TAP (lowest priority)
//   capture_data   parallel capture values, TDR k at [k*DR_LEN +: DR_LEN]
//   TDO            serial data out, combinational from the active target
//   DR_out         update-stage contents, same slicing as capture_data
//   update_strobe  one-cycle pulse on the TDR whose update stage was written
//   length_err     sticky until next capture: session shift count != DR_LEN
// -----------------------------------------------------------------------------
module jtag_tdr_bank #(
  parameter int NUM_TDR = 4,
  parameter int DR_LEN  = 8,
  parameter int SEL_W   = 2
) (
  input  logic                        TCK,
  input  logic                        RST,
  input  logic                        tdr_en,
  input  logic [SEL_W-1:0]            tdr_sel,
  input  logic                        TDI,
  input  logic                        Capture_DR,
  input  logic                        Shift_DR,
  input  logic                        Update_DR,
  input  logic [NUM_TDR*DR_LEN-1:0]   capture_data,
  output logic                        TDO,
  output logic [NUM_TDR*DR_LEN-1:0]   DR_out,
  output logic [NUM_TDR-1:0]          update_strobe,
  output logic                        length_err
);

  // The counter must hold DR_LEN+1, so that an over-shift saturates instead
  // of wrapping back to a value that looks legal.
  localparam int CNT_W = $clog2(DR_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DR_LEN + 1);

  logic [DR_LEN-1:0] sh [NUM_TDR];   // shift stages
  logic [DR_LEN-1:0] up [NUM_TDR];   // update stages
  logic              byp;            // bypass register
  logic [SEL_W-1:0]  sel_q;          // session target index
  logic              byp_q;          // session targets bypass
  logic [CNT_W-1:0]  cnt;            // shifts seen this session

  logic              cap_byp;        // target that a capture this cycle selects
  logic [NUM_TDR-1:0] cap_hit;       // one-hot TDR that a capture would load
  logic [NUM_TDR-1:0] act_hit;       // one-hot TDR of the current session

  // An out-of-range index cannot address a TDR, so it falls back to bypass.
  // That keeps every later access through sel_q in range.
  assign cap_byp = !tdr_en || (32'(tdr_sel) >= NUM_TDR);

  // NOTE: every signal written in always_comb gets a default value first.
  // Without the default, a path that skips the assignment would infer a latch.
  always_comb begin
    cap_hit = '0;
    act_hit = '0;
    for (int k = 0; k < NUM_TDR; k++) begin
      cap_hit[k] = !cap_byp && (32'(tdr_sel) == k);
      act_hit[k] = !byp_q   && (32'(sel_q)   == k);
    end
  end

  // TDO follows the active target directly. The TAP retimes it to the
  // falling edge, so no output register is needed here.
  always_comb begin
    TDO = byp_q & byp;
    for (int k = 0; k < NUM_TDR; k++) begin
      if (act_hit[k]) TDO = sh[k][0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All
  // registers then sample their inputs at the same clock edge, whatever
  // order the statements appear in.
  always_ff @(posedge TCK) begin
    // Default the strobe low, so that it can only ever be a one-cycle pulse.
    update_strobe <= '0;

    if (RST) begin
      // NOTE: the shift and update arrays are reset explicitly. They are
      // visible state (DR_out and TDO must read 0 after reset), not scratch
      // memory that can be left uninitialised.
      for (int k = 0; k < NUM_TDR; k++) begin
        sh[k] <= '0;
        up[k] <= '0;
      end
      byp        <= 1'b0;
      sel_q      <= '0;
      byp_q      <= 1'b1;
      cnt        <= '0;
      length_err <= 1'b0;
    end else if (Capture_DR) begin
      // Open a new session. If Shift or Update is asserted in the same
      // cycle, it is ignored.
      sel_q      <= tdr_sel;
      byp_q      <= cap_byp;
      cnt        <= '0;
      length_err <= 1'b0;
      if (cap_byp) byp <= 1'b0;
      for (int k = 0; k < NUM_TDR; k++) begin
        if (cap_hit[k]) sh[k] <= capture_data[k*DR_LEN +: DR_LEN];
      end
    end else if (Shift_DR) begin
      // Data shifts LSB-out: TDI enters at the MSB and bit 0 drives TDO.
      if (byp_q) byp <= TDI;
      for (int k = 0; k < NUM_TDR; k++) begin
        if (act_hit[k]) sh[k] <= {TDI, sh[k][DR_LEN-1:1]};
      end
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end else if (Update_DR && !byp_q) begin
      // A wrong shift count means the shift stage holds a misaligned value.
      // Block the update rather than commit corrupt data.
      if (cnt == CNT_FULL) begin
        for (int k = 0; k < NUM_TDR; k++) begin
          if (act_hit[k]) begin
            up[k]            <= sh[k];
            update_strobe[k] <= 1'b1;
          end
        end
      end else begin
        length_err <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_TDR; g++) begin : g_dr_out
    assign DR_out[g*DR_LEN +: DR_LEN] = up[g];
  end

endmodule

// File: tb/tb_jtag_tdr_bank.sv
// -----------------------------------------------------------------------------
// tb_jtag_tdr_bank
//
// Self-checking bench for jtag_tdr_bank. A session-level model tracks the
// active target as a bit queue: capture fills it LSB-first, and a shift
// pushes TDI at the back and drops the front. An update commits the queue
// only when the session shifted exactly DR_LEN bits. A compare process checks
// every output against the model on each falling edge. Directed scenarios add
// literal expectations on top of the model checks.
// -----------------------------------------------------------------------------
module tb_jtag_tdr_bank;

  localparam int NUM_TDR = 4;
  localparam int DR_LEN  = 8;
  localparam int SEL_W   = 2;
  localparam int W       = NUM_TDR * DR_LEN;

  logic               TCK = 1'b0;
  logic               RST = 1'b1;
  logic               tdr_en = 1'b0;
  logic [SEL_W-1:0]   tdr_sel = '0;
  logic               TDI = 1'b0;
  logic               Capture_DR = 1'b0;
  logic               Shift_DR = 1'b0;
  logic               Update_DR = 1'b0;
  logic [W-1:0]       capture_data = '0;
  logic               TDO;
  logic [W-1:0]       DR_out;
  logic [NUM_TDR-1:0] update_strobe;
  logic               length_err;

  jtag_tdr_bank #(.NUM_TDR(NUM_TDR), .DR_LEN(DR_LEN), .SEL_W(SEL_W)) dut (
    .TCK           (TCK),
    .RST           (RST),
    .tdr_en        (tdr_en),
    .tdr_sel       (tdr_sel),
    .TDI           (TDI),
    .Capture_DR    (Capture_DR),
    .Shift_DR      (Shift_DR),
    .Update_DR     (Update_DR),
    .capture_data  (capture_data),
    .TDO           (TDO),
    .DR_out        (DR_out),
    .update_strobe (update_strobe),
    .length_err    (length_err)
  );

  always #5 TCK = ~TCK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [DR_LEN-1:0]  m_up [NUM_TDR];
  bit                 m_q[$];        // active target contents, front = TDO bit
  bit                 m_byp;
  int                 m_sel;
  int                 m_cnt;
  bit                 m_lerr;
  logic [NUM_TDR-1:0] m_strobe;
  bit                 cmp_en = 1'b0;

  function automatic void model_reset();
    for (int k = 0; k < NUM_TDR; k++) m_up[k] = '0;
    m_q.delete();
    m_q.push_back(1'b0);
    m_byp    = 1'b1;
    m_sel    = 0;
    m_cnt    = 0;
    m_lerr   = 1'b0;
    m_strobe = '0;
  endfunction

  // Applies the rules for one rising edge to the inputs currently driven.
  function automatic void model_edge();
    m_strobe = '0;
    if (RST) begin
      model_reset();
    end else if (Capture_DR) begin
      m_sel  = int'(tdr_sel);
      m_byp  = !tdr_en || (m_sel >= NUM_TDR);
      m_cnt  = 0;
      m_lerr = 1'b0;
      m_q.delete();
      if (m_byp) m_q.push_back(1'b0);
      else for (int i = 0; i < DR_LEN; i++) m_q.push_back(capture_data[m_sel*DR_LEN + i]);
    end else if (Shift_DR) begin
      m_q.push_back(TDI);
      void'(m_q.pop_front());
      m_cnt++;
    end else if (Update_DR && !m_byp) begin
      if (m_cnt == DR_LEN) begin
        for (int i = 0; i < DR_LEN; i++) m_up[m_sel][i] = m_q[i];
        m_strobe[m_sel] = 1'b1;
      end else begin
        m_lerr = 1'b1;
      end
    end
  endfunction

  function automatic logic [W-1:0] exp_dr();
    logic [W-1:0] v = '0;
    for (int k = 0; k < NUM_TDR; k++) v[k*DR_LEN +: DR_LEN] = m_up[k];
    return v;
  endfunction

  always @(negedge TCK) begin
    if (cmp_en) begin
      check("tdo",        64'(TDO),           64'(m_q[0]));
      check("dr_out",     64'(DR_out),        64'(exp_dr()));
      check("strobe",     64'(update_strobe), 64'(m_strobe));
      check("length_err", 64'(length_err),    64'(m_lerr));
    end
  end

  // ------------------------------------------------------------- drivers
  // Inputs change 1 time unit after the rising edge. The model therefore
  // reads the same values that the DUT samples.
  task automatic cycle();
    @(posedge TCK);
    model_edge();
    cmp_en = 1'b1;
    #1;
  endtask

  task automatic drive(input bit c, input bit s, input bit u, input bit d);
    Capture_DR = c;
    Shift_DR   = s;
    Update_DR  = u;
    TDI        = d;
    cycle();
    Capture_DR = 1'b0;
    Shift_DR   = 1'b0;
    Update_DR  = 1'b0;
  endtask

  logic [7:0] pat_a5 = 8'hA5;
  logic [7:0] pat_3c = 8'h3C;
  logic [2:0] byp_in = 3'b101;   // bit order: 1,0,1
  logic [2:0] byp_ex = 3'b010;   // bit order: 0,1,0

  initial begin
    // Reset
    cycle();
    cycle();
    RST = 1'b0;
    check("reset_tdo",    64'(TDO),           64'h0);
    check("reset_dr_out", 64'(DR_out),        64'h0);
    check("reset_strobe", 64'(update_strobe), 64'h0);
    check("reset_lerr",   64'(length_err),    64'h0);

    // Full-length session into TDR 1
    capture_data        = '0;
    capture_data[15:8]  = 8'hA5;
    tdr_en  = 1'b1;
    tdr_sel = 2'd1;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      check("t1_tdo", 64'(TDO), 64'(pat_a5[i]));
      drive(0, 1, 0, pat_3c[i]);
    end
    drive(0, 0, 1, 0);
    check("t1_dr_out", 64'(DR_out),        64'h0000_3C00);
    check("t1_strobe", 64'(update_strobe), 64'h2);
    check("t1_lerr",   64'(length_err),    64'h0);
    drive(0, 0, 0, 0);
    check("t1_strobe_off", 64'(update_strobe), 64'h0);

    // Short session: update blocked, error flagged, next capture clears it
    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 1'b1);
    drive(0, 0, 1, 0);
    check("t2_dr_out", 64'(DR_out),        64'h0000_3C00);
    check("t2_strobe", 64'(update_strobe), 64'h0);
    check("t2_lerr",   64'(length_err),    64'h1);
    drive(1, 0, 0, 0);
    check("t2_lerr_clr", 64'(length_err), 64'h0);

    // Bypass path
    tdr_en = 1'b0;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("t3_tdo", 64'(TDO), 64'(byp_ex[i]));
      drive(0, 1, 0, byp_in[i]);
    end
    drive(0, 0, 1, 0);
    check("t3_dr_out", 64'(DR_out),        64'h0000_3C00);
    check("t3_strobe", 64'(update_strobe), 64'h0);
    check("t3_lerr",   64'(length_err),    64'h0);

    // The selection is latched at capture; later tdr_sel changes have no effect
    tdr_en  = 1'b1;
    tdr_sel = 2'd2;
    capture_data[23:16] = 8'h00;
    drive(1, 0, 0, 0);
    tdr_sel = 2'd0;
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 1'b1);
    drive(0, 0, 1, 0);
    check("t4_dr_out", 64'(DR_out),        64'h00FF_3C00);
    check("t4_strobe", 64'(update_strobe), 64'h4);

    // A reset in the middle of a session aborts it
    tdr_sel = 2'd3;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 1'b1);
    RST = 1'b1;
    drive(0, 0, 0, 0);
    RST = 1'b0;
    drive(0, 0, 1, 0);
    check("t5_dr_out", 64'(DR_out),        64'h0);
    check("t5_tdo",    64'(TDO),           64'h0);
    check("t5_strobe", 64'(update_strobe), 64'h0);

    // Capture and Update in the same cycle: capture wins
    tdr_sel = 2'd0;
    capture_data[7:0] = 8'h81;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 1'b0);
    drive(1, 0, 1, 0);
    check("t6_dr_out", 64'(DR_out),        64'h0);
    check("t6_strobe", 64'(update_strobe), 64'h0);
    check("t6_tdo",    64'(TDO),           64'h1);
    check("t6_lerr",   64'(length_err),    64'h0);

    // Randomised sessions
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 24) == 0) begin
        RST = 1'b1;
        drive(0, 0, 0, 0);
        RST = 1'b0;
      end
      capture_data = {$urandom(), $urandom()};
      tdr_en  = ($urandom_range(0, 4) != 0);
      tdr_sel = SEL_W'($urandom());
      drive(1, 0, 0, 0);
      begin
        int n;
        n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : DR_LEN;
        for (int j = 0; j < n; j++) begin
          if ($urandom_range(0, 5) == 0) begin
            tdr_en  = $urandom_range(0, 1);
            tdr_sel = SEL_W'($urandom());
            drive(0, 0, 0, 0);
          end
          drive(0, 1, ($urandom_range(0, 7) == 0), $urandom_range(0, 1));
        end
      end
      drive(($urandom_range(0, 9) == 0), 0, 1, 0);
      drive(0, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
